// File: rtl/dot_accumulator.sv
// Accumulates LEN valid partial sums from a fixed-latency multiply-add stage
// into one dot product, delivered on a valid/ready handshake.
module dot_accumulator #(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40,
   parameter int LEN       = 8,
   parameter int PIPE_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [WIDTH-1:0]     sum_in,
   input  logic                 clear,
   output logic [ACC_WIDTH-1:0] res_data,
   output logic                 res_overflow,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 busy
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

   logic [PIPE_LAT-1:0]  vpipe_q, vpipe_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
   logic                 res_ovf_q, res_ovf_d;
   logic                 res_valid_q, res_valid_d;

   logic                 item_v;
   logic                 issue_acc;
   logic                 first;
   logic [ACC_WIDTH:0]   sum_w;
   logic                 ovf_new;

   assign item_v      = vpipe_q[PIPE_LAT-1];
   assign issue_ready = !res_valid_q || res_ready;
   assign issue_acc   = issue_valid && issue_ready;
   assign first       = (cnt_q == '0);

   // Extra top bit of sum_w is the carry-out of the wrapping accumulator.
   assign sum_w   = {1'b0, (first ? {ACC_WIDTH{1'b0}} : acc_q)} + (ACC_WIDTH+1)'(sum_in);
   assign ovf_new = (first ? 1'b0 : ovf_q) | sum_w[ACC_WIDTH];

   always_comb begin
      vpipe_d     = vpipe_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      res_valid_d = res_valid_q;

      if (res_valid_q && res_ready)
         res_valid_d = 1'b0;

      if (clear) begin
         vpipe_d = '0;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         vpipe_d = PIPE_LAT'({vpipe_q, issue_acc});
         if (item_v) begin
            acc_d = sum_w[ACC_WIDTH-1:0];
            ovf_d = ovf_new;
            if (cnt_q == CNT_W'(LEN - 1)) begin
               cnt_d       = '0;
               res_data_d  = sum_w[ACC_WIDTH-1:0];
               res_ovf_d   = ovf_new;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vpipe_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         vpipe_q     <= vpipe_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign res_data     = res_data_q;
   assign res_overflow = res_ovf_q;
   assign res_valid    = res_valid_q;
   assign busy         = (cnt_q != '0) || (|vpipe_q);

endmodule
